// File: rtl/det_frame_sched_pkg.sv
// Shared types and constants for the det_frame_sched round-robin detector scheduler.
package det_frame_sched_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN1 = 3'd3,
        ST_DRAIN2 = 3'd4,
        ST_REPORT = 3'd5
    } state_t;

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/det_frame_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping 3 -> 0.
module det_frame_sched_rr_pick
    import det_frame_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    logic [ID_W-1:0] idx;

    // Walk from the farthest offset down so the nearest set request wins last.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + ID_W'(i);
            if (req[idx]) begin
                valid = 1'b1;
                id    = idx;
            end
        end
    end

endmodule

// File: rtl/det_frame_sched.sv
// Round-robin frame scheduler sharing one external "1 then 0" detector among four requesters.
//  state  | meaning
//  IDLE   | waiting for any request; picks next requester round-robin
//  CLEAR  | detector cleared, counters zeroed (1 cycle)
//  STREAM | frame bits forwarded to the detector (len cycles)
//  DRAIN1 | last bit presented to the detector; hits still counted
//  DRAIN2 | detector pipeline flush; last hit counted
//  REPORT | done strobe with id and hit count (1 cycle)
module det_frame_sched
    import det_frame_sched_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] bit_in,
    input  logic [LEN_W-1:0]   frame_len,
    input  logic               det_out,
    output logic [NUM_REQ-1:0] gnt,
    output logic               det_clr,
    output logic               det_in,
    output logic               busy,
    output logic               done,
    output logic [ID_W-1:0]    done_id,
    output logic [CNT_W-1:0]   hit_cnt
);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   hits_q, hits_d;
    logic               det_out_q, det_out_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               det_clr_q, det_clr_d;
    logic               det_in_q, det_in_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;
    logic               hit;
    logic               counting;

    det_frame_sched_rr_pick u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .id    (pick_id)
    );

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        len_d     = len_q;
        bit_cnt_d = bit_cnt_q;
        hits_d    = hits_q;
        det_out_d = det_out;
        rr_ptr_d  = rr_ptr_q;
        det_clr_d = 1'b0;
        det_in_d  = 1'b0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        hit_cnt_d = hit_cnt_q;

        hit      = det_out & ~det_out_q;
        counting = (state_q == ST_STREAM) || (state_q == ST_DRAIN1) || (state_q == ST_DRAIN2);
        if (counting && hit && (hits_q != '1)) begin
            hits_d = hits_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    id_d      = pick_id;
                    len_d     = frame_len;
                    det_clr_d = 1'b1;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                bit_cnt_d = '0;
                hits_d    = '0;
                det_out_d = 1'b0;
                state_d   = (len_q == '0) ? ST_DRAIN1 : ST_STREAM;
            end
            ST_STREAM: begin
                det_in_d = bit_in[id_q];
                if (bit_cnt_q == len_q - LEN_W'(1)) begin
                    state_d = ST_DRAIN1;
                end else begin
                    bit_cnt_d = bit_cnt_q + LEN_W'(1);
                end
            end
            ST_DRAIN1: begin
                state_d = ST_DRAIN2;
            end
            // Report outputs load here so they are visible during REPORT, including this cycle's hit.
            ST_DRAIN2: begin
                done_d    = 1'b1;
                done_id_d = id_q;
                hit_cnt_d = hits_d;
                state_d   = ST_REPORT;
            end
            ST_REPORT: begin
                rr_ptr_d = id_q + ID_W'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        gnt_d  = (state_d != ST_IDLE) ? id_onehot(id_d) : '0;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            hits_q    <= '0;
            det_out_q <= 1'b0;
            rr_ptr_q  <= '0;
            gnt_q     <= '0;
            det_clr_q <= 1'b1;
            det_in_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            len_q     <= len_d;
            bit_cnt_q <= bit_cnt_d;
            hits_q    <= hits_d;
            det_out_q <= det_out_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_q     <= gnt_d;
            det_clr_q <= det_clr_d;
            det_in_q  <= det_in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign det_clr = det_clr_q;
    assign det_in  = det_in_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_det_frame_sched.sv
// Directed bench for det_frame_sched with a behavioural "1 then 0" detector per DUT instance.
module tb_det_frame_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic [3:0] bit_in = 4'b0;
    logic [7:0] frame_len = 8'd0;

    logic [3:0] gnt;
    logic       det_clr, det_in, busy, done;
    logic [1:0] done_id;
    logic [7:0] hit_cnt;
    logic       det_out = 1'b0;
    logic       det_s = 1'b0;

    logic [3:0] gnt_s;
    logic       det_clr_s, det_in_s, busy_s, done_s;
    logic [1:0] done_id_s;
    logic [1:0] hit_cnt_s;
    logic       det_out_s = 1'b0;
    logic       det_s2 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    det_frame_sched #(.LEN_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .bit_in(bit_in), .frame_len(frame_len),
        .det_out(det_out), .gnt(gnt), .det_clr(det_clr), .det_in(det_in), .busy(busy),
        .done(done), .done_id(done_id), .hit_cnt(hit_cnt)
    );

    det_frame_sched #(.LEN_W(8), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .req(req), .bit_in(bit_in), .frame_len(frame_len),
        .det_out(det_out_s), .gnt(gnt_s), .det_clr(det_clr_s), .det_in(det_in_s), .busy(busy_s),
        .done(done_s), .done_id(done_id_s), .hit_cnt(hit_cnt_s)
    );

    // Registered Moore detector: output goes high the cycle after a 0 follows a 1.
    always @(posedge clk) begin
        if (det_clr) begin
            det_s   <= 1'b0;
            det_out <= 1'b0;
        end else begin
            det_out <= det_s & ~det_in;
            det_s   <= det_in;
        end
    end

    always @(posedge clk) begin
        if (det_clr_s) begin
            det_s2    <= 1'b0;
            det_out_s <= 1'b0;
        end else begin
            det_out_s <= det_s2 & ~det_in_s;
            det_s2    <= det_in_s;
        end
    end

    // Called at the negedge of the IDLE cycle in which req is already driven; returns at the
    // negedge of the IDLE cycle following REPORT.
    task automatic do_frame(input string tag, input logic [1:0] id, input int len,
                            input logic [31:0] pat, input logic [7:0] exp_hits, input int drop_c);
        logic [3:0] oh;
        logic [3:0] exp_gnt;
        logic       exp_din;
        oh = 4'b0001 << id;
        for (int c = 1; c <= len + 5; c++) begin
            @(negedge clk);
            if (c == drop_c) begin
                req       = 4'b0;
                frame_len = 8'd1;
            end
            exp_gnt = (c <= len + 4) ? oh : 4'b0;
            exp_din = (c >= 3 && c <= len + 2) ? pat[c-3] : 1'b0;
            checks++;
            if (gnt !== exp_gnt) begin
                errors++;
                $display("FAIL %s gnt c=%0d got %b exp %b", tag, c, gnt, exp_gnt);
            end
            checks++;
            if (busy !== (c <= len + 4)) begin
                errors++;
                $display("FAIL %s busy c=%0d got %b exp %b", tag, c, busy, (c <= len + 4));
            end
            checks++;
            if (done !== (c == len + 4)) begin
                errors++;
                $display("FAIL %s done c=%0d got %b exp %b", tag, c, done, (c == len + 4));
            end
            checks++;
            if (det_clr !== (c == 1)) begin
                errors++;
                $display("FAIL %s det_clr c=%0d got %b exp %b", tag, c, det_clr, (c == 1));
            end
            checks++;
            if (det_in !== exp_din) begin
                errors++;
                $display("FAIL %s det_in c=%0d got %b exp %b", tag, c, det_in, exp_din);
            end
            if (c == len + 4) begin
                checks++;
                if (done_id !== id) begin
                    errors++;
                    $display("FAIL %s done_id got %0d exp %0d", tag, done_id, id);
                end
                checks++;
                if (hit_cnt !== exp_hits) begin
                    errors++;
                    $display("FAIL %s hit_cnt got %0d exp %0d", tag, hit_cnt, exp_hits);
                end
            end
            if (c >= 2 && c <= len + 1) bit_in = pat[c-2] ? oh : ~oh;
            else bit_in = 4'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || det_in !== 1'b0) begin
            errors++;
            $display("FAIL reset outs got gnt=%b busy=%b done=%b det_in=%b exp 0", gnt, busy, done, det_in);
        end
        checks++;
        if (det_clr !== 1'b1) begin
            errors++;
            $display("FAIL reset det_clr got %b exp 1", det_clr);
        end
        checks++;
        if (hit_cnt !== 8'd0 || done_id !== 2'd0) begin
            errors++;
            $display("FAIL reset hit_cnt/done_id got %0d/%0d exp 0/0", hit_cnt, done_id);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (det_clr !== 1'b1) begin
            errors++;
            $display("FAIL reset det_clr_before_edge got %b exp 1", det_clr);
        end
        @(negedge clk);
        checks++;
        if (det_clr !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset release got det_clr=%b busy=%b exp 0/0", det_clr, busy);
        end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        req       = 4'b1111;
        frame_len = 8'd2;
        for (int k = 0; k < 5; k++) begin
            do_frame("rr", 2'(k), 2, 32'h1, 8'd1, -1);
        end
        req = 4'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req       = 4'b0001;
        frame_len = 8'd6;
        do_frame("single", 2'd0, 6, 32'd25, 8'd2, -1);
        req = 4'b0;
    endtask

    task automatic test_zero_len();
        @(negedge clk);
        req       = 4'b0100;
        frame_len = 8'd0;
        do_frame("zero", 2'd2, 0, 32'd0, 8'd0, -1);
        req = 4'b0;
    endtask

    task automatic test_last_bit();
        @(negedge clk);
        req       = 4'b0010;
        frame_len = 8'd4;
        do_frame("lastbit", 2'd1, 4, 32'd7, 8'd1, -1);
        req = 4'b0;
    endtask

    task automatic test_saturation();
        @(negedge clk);
        req       = 4'b1000;
        frame_len = 8'd16;
        do_frame("sat", 2'd3, 16, 32'h5555, 8'd8, -1);
        req = 4'b0;
        checks++;
        if (hit_cnt_s !== 2'd3) begin
            errors++;
            $display("FAIL sat hit_cnt_narrow got %0d exp 3", hit_cnt_s);
        end
        checks++;
        if (done_id_s !== 2'd3 || gnt_s !== 4'b0 || busy_s !== 1'b0 || done_s !== 1'b0
            || det_clr_s !== 1'b0 || det_in_s !== 1'b0) begin
            errors++;
            $display("FAIL sat narrow_idle got id=%0d gnt=%b busy=%b done=%b clr=%b din=%b",
                     done_id_s, gnt_s, busy_s, done_s, det_clr_s, det_in_s);
        end
    endtask

    task automatic test_req_drop();
        @(negedge clk);
        req       = 4'b0001;
        frame_len = 8'd6;
        do_frame("drop", 2'd0, 6, 32'd25, 8'd2, 4);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0) begin
            errors++;
            $display("FAIL drop regrant got busy=%b gnt=%b exp 0", busy, gnt);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req       = 4'b0100;
        frame_len = 8'd6;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (gnt !== 4'b0100) begin
                    errors++;
                    $display("FAIL rstmid gnt got %b exp 0100", gnt);
                end
            end
            bit_in = 4'b1111;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0 || busy !== 1'b0 || done !== 1'b0 || det_in !== 1'b0 || det_clr !== 1'b1) begin
            errors++;
            $display("FAIL rstmid async got gnt=%b busy=%b done=%b din=%b clr=%b", gnt, busy, done, det_in, det_clr);
        end
        checks++;
        if (hit_cnt !== 8'd0 || done_id !== 2'd0) begin
            errors++;
            $display("FAIL rstmid hold got hit_cnt=%0d done_id=%0d exp 0/0", hit_cnt, done_id);
        end
        bit_in = 4'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL rstmid done got %b exp 0", done);
            end
        end
        req       = 4'b0101;
        frame_len = 8'd2;
        rst_n     = 1'b1;
        do_frame("postrst", 2'd0, 2, 32'h1, 8'd1, -1);
        req = 4'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_zero_len();
        test_last_bit();
        test_saturation();
        test_req_drop();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
